// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default line/clock constants and the
// oversampling divider calculation shared by the receiver and transmitter.
// Optional feature macro: UART_RX_PARITY_EN (adds the even-parity state).
package uart_pkg;

    localparam int unsigned DefaultClkHz     = 50_000_000;
    localparam int unsigned DefaultBaud      = 9600;
    localparam int unsigned DefaultOversample = 16;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop,
        StWaitIdle
    } uart_state_e;

    // Clock cycles per oversampling tick, never below one.
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned baud,
                                             input int unsigned oversample);
        int unsigned d;
        d = clk_hz / (baud * oversample);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-cycle tick every Div clocks.
// With Div == 1 the tick is permanently high.
module uart_baud_tick #(
    parameter int unsigned Div = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick_o
);

    localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(Div - 1);

    logic [CntW-1:0] cnt_q;

    // Count 0..Div-1 and wrap.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (cnt_q == CntMax) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    assign tick_o = (cnt_q == CntMax);

endmodule

// File: rtl/uart_rx_sampler.sv
// Oversampling UART receiver: synchronises the line, validates the start bit at its
// centre, samples data/stop at bit centres and emits registered one-cycle pulses.
// Optional feature macro: UART_RX_PARITY_EN (one even-parity bit after D7).
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = DefaultClkHz,
    parameter int unsigned BAUD       = DefaultBaud,
    parameter int unsigned OVERSAMPLE = DefaultOversample
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic       iRx,
    output logic [7:0] oData,
    output logic       oValid,
    output logic       oFrameErr,
    output logic       oParityErr,
    output logic       oBusy
);

    localparam int unsigned Div   = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int unsigned ScntW = $clog2(OVERSAMPLE);
    localparam logic [ScntW-1:0] ScntMid  = ScntW'(OVERSAMPLE / 2 - 1);
    localparam logic [ScntW-1:0] ScntLast = ScntW'(OVERSAMPLE - 1);

    logic rx_meta_q;
    logic rx_s_q;
    logic tick;

    uart_state_e      state_q;
    logic [ScntW-1:0] scnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic [7:0]       data_q;
    logic             valid_q;
    logic             ferr_q;
    logic             busy_q;
`ifdef UART_RX_PARITY_EN
    logic             par_q;
    logic             perr_q;
`endif

    // Two-flop synchroniser; idle-high reset so reset never looks like a start bit.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= iRx;
            rx_s_q    <= rx_meta_q;
        end
    end

    uart_baud_tick #(
        .Div (Div)
    ) u_baud_tick (
        .clk_i  (iClk),
        .rst_ni (iRst_n),
        .tick_o (tick)
    );

    // Receive FSM with registered data, pulses and busy flag.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q   <= StIdle;
            scnt_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
            // Lags the state by one cycle on both entry and exit of IDLE.
            busy_q  <= (state_q != StIdle);
            if (tick) begin
                unique case (state_q)
                    StIdle: begin
                        if (!rx_s_q) begin
                            state_q <= StStart;
                            scnt_q  <= '0;
                        end
                    end
                    StStart: begin
                        if (scnt_q == ScntMid) begin
                            scnt_q    <= '0;
                            bit_idx_q <= '0;
                            // A start bit that is gone by its centre is a glitch.
                            state_q   <= rx_s_q ? StIdle : StData;
                        end else begin
                            scnt_q <= scnt_q + ScntW'(1);
                        end
                    end
                    StData: begin
                        if (scnt_q == ScntLast) begin
                            shift_q   <= {rx_s_q, shift_q[7:1]};
                            bit_idx_q <= bit_idx_q + 3'd1;
                            scnt_q    <= '0;
                            if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                state_q <= StParity;
`else
                                state_q <= StStop;
`endif
                            end
                        end else begin
                            scnt_q <= scnt_q + ScntW'(1);
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    StParity: begin
                        if (scnt_q == ScntLast) begin
                            par_q   <= rx_s_q;
                            scnt_q  <= '0;
                            state_q <= StStop;
                        end else begin
                            scnt_q <= scnt_q + ScntW'(1);
                        end
                    end
`endif
                    StStop: begin
                        if (scnt_q == ScntLast) begin
                            scnt_q <= '0;
                            if (rx_s_q) begin
                                // Return to IDLE mid stop bit so a back-to-back start is seen.
                                state_q <= StIdle;
`ifdef UART_RX_PARITY_EN
                                if (par_q != ^shift_q) begin
                                    perr_q <= 1'b1;
                                end else begin
                                    data_q  <= shift_q;
                                    valid_q <= 1'b1;
                                end
`else
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
`endif
                            end else begin
                                ferr_q  <= 1'b1;
                                state_q <= StWaitIdle;
                            end
                        end else begin
                            scnt_q <= scnt_q + ScntW'(1);
                        end
                    end
                    StWaitIdle: begin
                        // Hold off until the break ends so it reports only once.
                        if (rx_s_q) begin
                            state_q <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign oData     = data_q;
    assign oValid    = valid_q;
    assign oFrameErr = ferr_q;
    assign oBusy     = busy_q;
`ifdef UART_RX_PARITY_EN
    assign oParityErr = perr_q;
`else
    assign oParityErr = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler at DIV=2, 32 clocks per bit.
// Optional feature macro: UART_RX_PARITY_EN (adds the parity scenarios).
module tb_uart_rx_sampler;

    localparam int unsigned ClkHz = 1_600_000;
    localparam int unsigned Baud  = 50_000;
    localparam int unsigned Os    = 16;
    localparam int BitCyc = 32;
`ifdef UART_RX_PARITY_EN
    localparam int FrameBits = 11;
    localparam int ParBits   = 1;
`else
    localparam int FrameBits = 10;
    localparam int ParBits   = 0;
`endif
    // Start-detect tick to mid-stop tick, in clocks.
    localparam int BusyCyc = (Os / 2 + (9 + ParBits) * Os) * 2;

    logic       iClk;
    logic       iRst_n;
    logic       iRx;
    logic [7:0] oData;
    logic       oValid;
    logic       oFrameErr;
    logic       oParityErr;
    logic       oBusy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int ferr_cnt = 0;
    int perr_cnt = 0;
    int busy_cnt = 0;
    logic [7:0] data_log [0:7];
    int cyc_log [0:7];

    uart_rx_sampler #(
        .CLK_HZ     (ClkHz),
        .BAUD       (Baud),
        .OVERSAMPLE (Os)
    ) dut (
        .iClk       (iClk),
        .iRst_n     (iRst_n),
        .iRx        (iRx),
        .oData      (oData),
        .oValid     (oValid),
        .oFrameErr  (oFrameErr),
        .oParityErr (oParityErr),
        .oBusy      (oBusy)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    always @(posedge iClk) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling edge.
    always @(negedge iClk) begin
        if (oValid) begin
            if (valid_cnt < 8) begin
                data_log[valid_cnt] = oData;
                cyc_log[valid_cnt]  = cyc;
            end
            valid_cnt = valid_cnt + 1;
        end
        if (oFrameErr) ferr_cnt = ferr_cnt + 1;
        if (oParityErr) perr_cnt = perr_cnt + 1;
        if (oBusy) busy_cnt = busy_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        valid_cnt = 0;
        ferr_cnt  = 0;
        perr_cnt  = 0;
        busy_cnt  = 0;
    endtask

    task automatic idle(input int n);
        iRx = 1'b1;
        repeat (n) @(posedge iClk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        iRx = b;
        repeat (BitCyc) @(posedge iClk);
        #1;
    endtask

    // Parity argument is used only when the parity bit is configured.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par);
`else
        if (par === 1'bx) $display("note: parity unused");
`endif
        drive_bit(stop);
    endtask

    initial begin
        int t0;
        int lat;
        int gap;
        iRst_n = 1'b0;
        iRx    = 1'b1;
        repeat (3) @(posedge iClk);
        #1;
        check("rst_data", {24'd0, oData}, 32'h00);
        check("rst_valid", {31'd0, oValid}, 32'd0);
        check("rst_ferr", {31'd0, oFrameErr}, 32'd0);
        check("rst_perr", {31'd0, oParityErr}, 32'd0);
        check("rst_busy", {31'd0, oBusy}, 32'd0);
        iRst_n = 1'b1;
        idle(20);

        // Single good frame with latency and busy width.
        clear_counts();
        t0 = cyc;
        send_frame(8'h5A, 1'b1, ^8'h5A);
        idle(40);
        lat = cyc_log[0] - t0;
        check("5a_valid_cnt", valid_cnt, 1);
        check("5a_data", {24'd0, data_log[0]}, 32'h5A);
        check("5a_ferr_cnt", ferr_cnt, 0);
        check($sformatf("5a_latency=%0d", lat),
              (lat >= BusyCyc + 1 && lat <= BusyCyc + 5) ? 1 : 0, 1);
        check($sformatf("5a_busy_cycles=%0d", busy_cnt),
              (busy_cnt >= BusyCyc - 4 && busy_cnt <= BusyCyc + 4) ? 1 : 0, 1);
        check("5a_busy_idle", {31'd0, oBusy}, 32'd0);

        // Back-to-back frames with no idle gap.
        clear_counts();
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        idle(40);
        gap = cyc_log[1] - cyc_log[0];
        check("b2b_valid_cnt", valid_cnt, 2);
        check("b2b_data0", {24'd0, data_log[0]}, 32'h00);
        check("b2b_data1", {24'd0, data_log[1]}, 32'hFF);
        check($sformatf("b2b_gap=%0d", gap),
              (gap >= FrameBits * BitCyc - 4 && gap <= FrameBits * BitCyc + 4) ? 1 : 0, 1);

        // Start-bit glitch of 8 clocks.
        clear_counts();
        iRx = 1'b0;
        repeat (8) @(posedge iClk);
        #1;
        idle(BitCyc);
        check("glitch_valid_cnt", valid_cnt, 0);
        check("glitch_ferr_cnt", ferr_cnt, 0);
        check("glitch_busy", {31'd0, oBusy}, 32'd0);

        // Good frame, framing error with held break, then recovery.
        clear_counts();
        send_frame(8'h11, 1'b1, ^8'h11);
        send_frame(8'hA5, 1'b0, ^8'hA5);
        iRx = 1'b0;
        repeat (3 * BitCyc) @(posedge iClk);
        #1;
        idle(64);
        check("brk_ferr_cnt", ferr_cnt, 1);
        check("brk_valid_cnt", valid_cnt, 1);
        check("brk_data_kept", {24'd0, oData}, 32'h11);
        send_frame(8'h42, 1'b1, ^8'h42);
        idle(40);
        check("brk_recover_cnt", valid_cnt, 2);
        check("brk_recover_data", {24'd0, oData}, 32'h42);

        // Asynchronous reset after four data bits.
        clear_counts();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(i[0]);
        iRst_n = 1'b0;
        #1;
        check("midrst_data", {24'd0, oData}, 32'h00);
        check("midrst_busy", {31'd0, oBusy}, 32'd0);
        check("midrst_valid", {31'd0, oValid}, 32'd0);
        check("midrst_ferr", {31'd0, oFrameErr}, 32'd0);
        iRx = 1'b1;
        repeat (4) @(posedge iClk);
        #1;
        iRst_n = 1'b1;
        idle(40);
        send_frame(8'h3C, 1'b1, ^8'h3C);
        idle(40);
        check("post_rst_cnt", valid_cnt, 1);
        check("post_rst_data", {24'd0, oData}, 32'h3C);

`ifdef UART_RX_PARITY_EN
        // Wrong then correct even parity for 0x81.
        clear_counts();
        send_frame(8'h81, 1'b1, 1'b1);
        idle(40);
        check("par_bad_perr", perr_cnt, 1);
        check("par_bad_valid", valid_cnt, 0);
        clear_counts();
        send_frame(8'h81, 1'b1, 1'b0);
        idle(40);
        check("par_good_valid", valid_cnt, 1);
        check("par_good_data", {24'd0, oData}, 32'h81);
`else
        check("noparity_perr", perr_cnt, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
